bdc_cmd_sequencer: RTL and testbench

// - Sequences high-level HCS08 BDC commands into the byte-level strobe interface of the bdm block.
// - Host issues one command (op, address, write data); the block emits the opcode byte, address bytes and data byte, plus the ACK delay.
// - It collects the read byte and returns one response per command.
// - Sits between the host command decoder (UART side) and bdm; it is the only driver of bdm's do_read/do_write/do_delay/data_in.

---
 rtl/bdc_pkg.sv | 26 ++
 rtl/bdc_step_rom.sv | 72 +++++++
 rtl/bdc_cmd_sequencer.sv | 150 +++++++++++++++
 tb/tb_bdc_cmd_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdc_pkg.sv
// Shared definitions for the HCS08 BDC command sequencer: host op codes, BDC command bytes and
// the kinds of byte-level step the sequencer hands to bdm.
package bdc_pkg;

   localparam logic [2:0] OP_BACKGROUND    = 3'd0;
   localparam logic [2:0] OP_GO            = 3'd1;
   localparam logic [2:0] OP_READ_STATUS   = 3'd2;
   localparam logic [2:0] OP_WRITE_CONTROL = 3'd3;
   localparam logic [2:0] OP_READ_BYTE     = 3'd4;
   localparam logic [2:0] OP_WRITE_BYTE    = 3'd5;

   localparam logic [7:0] CMD_BACKGROUND    = 8'h90;
   localparam logic [7:0] CMD_GO            = 8'h08;
   localparam logic [7:0] CMD_READ_STATUS   = 8'hE4;
   localparam logic [7:0] CMD_WRITE_CONTROL = 8'hC4;
   localparam logic [7:0] CMD_READ_BYTE     = 8'hE0;
   localparam logic [7:0] CMD_WRITE_BYTE    = 8'hC0;

   typedef enum logic [1:0] {
      KindW,
      KindD,
      KindR,
      KindEnd
   } step_kind_e;

endpackage

// File: rtl/bdc_step_rom.sv
// Combinational step table: maps (op, step index) to the byte-level action and its data byte.
module bdc_step_rom
   import bdc_pkg::*;
#(
   parameter logic [7:0] DELAY_ARG = 8'd4
) (
   input  logic [2:0]  op,
   input  logic [2:0]  step,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic [1:0]  kind,
   output logic [7:0]  data
);

   step_kind_e k;

   always_comb begin
      k    = KindEnd;
      data = 8'h00;
      case (op)
         OP_BACKGROUND, OP_GO: begin
            if (step == 3'd0) begin
               k    = KindW;
               data = (op == OP_GO) ? CMD_GO : CMD_BACKGROUND;
            end else if (step == 3'd1) begin
               k    = KindD;
               data = DELAY_ARG;
            end
         end
         OP_READ_STATUS: begin
            case (step)
               3'd0:    begin k = KindW; data = CMD_READ_STATUS; end
               3'd1:    begin k = KindD; data = DELAY_ARG; end
               3'd2:    k = KindR;
               default: ;
            endcase
         end
         OP_WRITE_CONTROL: begin
            case (step)
               3'd0:    begin k = KindW; data = CMD_WRITE_CONTROL; end
               3'd1:    begin k = KindW; data = wdata; end
               3'd2:    begin k = KindD; data = DELAY_ARG; end
               default: ;
            endcase
         end
         OP_READ_BYTE: begin
            case (step)
               3'd0:    begin k = KindW; data = CMD_READ_BYTE; end
               3'd1:    begin k = KindW; data = addr[15:8]; end
               3'd2:    begin k = KindW; data = addr[7:0]; end
               3'd3:    begin k = KindD; data = DELAY_ARG; end
               3'd4:    k = KindR;
               default: ;
            endcase
         end
         OP_WRITE_BYTE: begin
            case (step)
               3'd0:    begin k = KindW; data = CMD_WRITE_BYTE; end
               3'd1:    begin k = KindW; data = addr[15:8]; end
               3'd2:    begin k = KindW; data = addr[7:0]; end
               3'd3:    begin k = KindW; data = wdata; end
               3'd4:    begin k = KindD; data = DELAY_ARG; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign kind = k;

endmodule

// File: rtl/bdc_cmd_sequencer.sv
// Turns one host BDC command into a sequence of bdm write/delay/read strobes and returns a single
// response (read byte or error) per accepted command.
module bdc_cmd_sequencer
   import bdc_pkg::*;
#(
   parameter logic [7:0]  DELAY_ARG      = 8'd4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned TO_W           = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        resp_valid,
   output logic [7:0]  resp_data,
   output logic        resp_err,
   input  logic        bdm_ready,
   input  logic        bdm_valid,
   input  logic [7:0]  bdm_data_out,
   output logic        bdm_do_read,
   output logic        bdm_do_write,
   output logic        bdm_do_delay,
   output logic [7:0]  bdm_data_in
);

   typedef enum logic [2:0] {StIdle, StIssue, StLaunch, StWait, StResp} state_e;

   state_e          state;
   logic [2:0]      op;
   logic [15:0]     addr;
   logic [7:0]      wdata;
   logic [2:0]      step;
   logic [TO_W-1:0] to_cnt;
   logic [7:0]      rdata;
   logic            cur_read;
   logic [1:0]      rom_kind;
   logic [7:0]      rom_byte;
   logic            to_hit;

   // step already points past the outstanding step once it is launched, so in WAIT the ROM
   // tells us whether anything is left to issue.
   bdc_step_rom #(
      .DELAY_ARG(DELAY_ARG)
   ) u_rom (
      .op   (op),
      .step (step),
      .addr (addr),
      .wdata(wdata),
      .kind (rom_kind),
      .data (rom_byte)
   );

   assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= StIdle;
         cmd_ready    <= 1'b1;
         op           <= 3'd0;
         addr         <= 16'h0000;
         wdata        <= 8'h00;
         step         <= 3'd0;
         to_cnt       <= '0;
         rdata        <= 8'h00;
         cur_read     <= 1'b0;
         resp_valid   <= 1'b0;
         resp_data    <= 8'h00;
         resp_err     <= 1'b0;
         bdm_do_read  <= 1'b0;
         bdm_do_write <= 1'b0;
         bdm_do_delay <= 1'b0;
         bdm_data_in  <= 8'h00;
      end else begin
         bdm_do_read  <= 1'b0;
         bdm_do_write <= 1'b0;
         bdm_do_delay <= 1'b0;
         resp_valid   <= 1'b0;
         case (state)
            StIdle: begin
               if (cmd_valid) begin
                  op        <= cmd_op;
                  addr      <= cmd_addr;
                  wdata     <= cmd_wdata;
                  step      <= 3'd0;
                  rdata     <= 8'h00;
                  to_cnt    <= '0;
                  cmd_ready <= 1'b0;
                  if (cmd_op > OP_WRITE_BYTE) begin
                     state      <= StResp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_data  <= 8'h00;
                  end else begin
                     state <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (bdm_ready) begin
                  bdm_do_write <= (rom_kind == KindW);
                  bdm_do_delay <= (rom_kind == KindD);
                  bdm_do_read  <= (rom_kind == KindR);
                  bdm_data_in  <= rom_byte;
                  cur_read     <= (rom_kind == KindR);
                  step         <= step + 3'd1;
                  state        <= StLaunch;
               end else if (to_hit) begin
                  state      <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_data  <= 8'h00;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            StLaunch: state <= StWait;
            StWait: begin
               if (cur_read && bdm_valid) rdata <= bdm_data_out;
               if (bdm_ready) begin
                  if (rom_kind == KindEnd) begin
                     state      <= StResp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_data  <= (cur_read && bdm_valid) ? bdm_data_out : rdata;
                  end else begin
                     to_cnt <= '0;
                     state  <= StIssue;
                  end
               end else if (to_hit) begin
                  state      <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_data  <= 8'h00;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            StResp: begin
               state     <= StIdle;
               cmd_ready <= 1'b1;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bdc_cmd_sequencer.sv
// Bench for bdc_cmd_sequencer: a small bdm responder, a step/response plan derived from the BDC
// command tables, and one negedge process comparing every strobe and response against the plan.
module tb_bdc_cmd_sequencer;

   localparam logic [7:0]  DLY = 8'd4;
   localparam int unsigned TO  = 100;
   localparam logic [1:0]  K_W = 2'd0;
   localparam logic [1:0]  K_D = 2'd1;
   localparam logic [1:0]  K_R = 2'd2;

   typedef struct packed {logic [1:0] kind; logic [7:0] data;} step_t;
   typedef struct packed {logic err; logic [7:0] data;} resp_t;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        resp_valid;
   logic [7:0]  resp_data;
   logic        resp_err;
   logic        bdm_ready;
   logic        bdm_valid;
   logic [7:0]  bdm_data_out;
   logic        bdm_do_read;
   logic        bdm_do_write;
   logic        bdm_do_delay;
   logic [7:0]  bdm_data_in;

   bdc_cmd_sequencer #(
      .DELAY_ARG     (DLY),
      .TIMEOUT_CYCLES(TO),
      .TO_W          (20)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_err    (resp_err),
      .bdm_ready   (bdm_ready),
      .bdm_valid   (bdm_valid),
      .bdm_data_out(bdm_data_out),
      .bdm_do_read (bdm_do_read),
      .bdm_do_write(bdm_do_write),
      .bdm_do_delay(bdm_do_delay),
      .bdm_data_in (bdm_data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // bdm responder: drops ready after a strobe, returns it a few cycles later; a read step gets
   // a valid pulse with read_val, other steps get a junk valid pulse that must be ignored.
   logic       stuck;
   logic [7:0] read_val;
   int         busy;
   logic       pend_read;

   always @(posedge clk) begin
      if (rst) begin
         bdm_ready    <= 1'b1;
         bdm_valid    <= 1'b0;
         bdm_data_out <= 8'h00;
         busy         <= 0;
         pend_read    <= 1'b0;
      end else begin
         bdm_valid <= 1'b0;
         if (bdm_do_read || bdm_do_write || bdm_do_delay) begin
            bdm_ready <= 1'b0;
            busy      <= 5;
            pend_read <= bdm_do_read;
         end else if (!bdm_ready && !stuck) begin
            busy <= busy - 1;
            if (busy == 2) begin
               bdm_valid    <= 1'b1;
               bdm_data_out <= pend_read ? read_val : 8'h5A;
            end
            if (busy == 1) bdm_ready <= 1'b1;
         end
      end
   end

   step_t exp_steps[$];
   resp_t exp_resp[$];
   step_t log_steps[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    plan_left;
   int    nidx = 0;
   int    rise_n = -100;
   int    acc_n = 0;
   int    resp_n = 0;
   int    strobe_n = 0;
   int    resp_count = 0;
   logic  prev_ready = 1'b1;
   logic  want_first = 1'b0;
   resp_t last_resp;
   int    ns;
   step_t s_obs;
   step_t s_exp;
   resp_t r_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void add(input logic [1:0] k, input logic [7:0] b);
      step_t s;
      if (plan_left > 0) begin
         s.kind = k;
         s.data = b;
         exp_steps.push_back(s);
         plan_left--;
      end
   endfunction

   // Expected bdm step list and response for one command, straight from the BDC command table.
   function automatic void plan(input logic [2:0] op, input logic [15:0] a, input logic [7:0] wd,
                                input logic [7:0] rd, input int keep, input bit with_resp,
                                input bit timeout);
      resp_t r;
      plan_left = keep;
      case (op)
         3'd0: begin add(K_W, 8'h90); add(K_D, DLY); end
         3'd1: begin add(K_W, 8'h08); add(K_D, DLY); end
         3'd2: begin add(K_W, 8'hE4); add(K_D, DLY); add(K_R, 8'h00); end
         3'd3: begin add(K_W, 8'hC4); add(K_W, wd); add(K_D, DLY); end
         3'd4: begin
            add(K_W, 8'hE0); add(K_W, a[15:8]); add(K_W, a[7:0]); add(K_D, DLY); add(K_R, 8'h00);
         end
         3'd5: begin
            add(K_W, 8'hC0); add(K_W, a[15:8]); add(K_W, a[7:0]); add(K_W, wd); add(K_D, DLY);
         end
         default: ;
      endcase
      r.err  = timeout || (op > 3'd5);
      r.data = (r.err || !(op == 3'd2 || op == 3'd4)) ? 8'h00 : rd;
      if (with_resp) exp_resp.push_back(r);
   endfunction

   always @(negedge clk) begin
      nidx++;
      if (!rst) begin
         ns = int'(bdm_do_read) + int'(bdm_do_write) + int'(bdm_do_delay);
         if (bdm_ready && !prev_ready) rise_n = nidx;
         prev_ready = bdm_ready;
         if (cmd_valid && cmd_ready) begin
            acc_n      = nidx;
            want_first = 1'b1;
         end
         if (ns > 1) check("strobe_exclusive", ns, 1);
         if (ns != 0) begin
            s_obs.kind = bdm_do_write ? K_W : (bdm_do_delay ? K_D : K_R);
            s_obs.data = bdm_data_in;
            log_steps.push_back(s_obs);
            strobe_n = nidx;
            check("strobe_while_ready", bdm_ready, 1);
            if (want_first) begin
               check("first_strobe_latency_ge2", (nidx - acc_n) >= 2, 1);
               want_first = 1'b0;
            end
            if (exp_steps.size() == 0) begin
               check("unexpected_strobe", ns, 0);
            end else begin
               s_exp = exp_steps.pop_front();
               check("step_kind", s_obs.kind, s_exp.kind);
               if (s_exp.kind != K_R) check("step_byte", s_obs.data, s_exp.data);
            end
         end
         if (resp_valid) begin
            resp_count++;
            resp_n         = nidx;
            want_first     = 1'b0;
            last_resp.err  = resp_err;
            last_resp.data = resp_data;
            if (exp_resp.size() == 0) begin
               check("unexpected_resp", resp_valid, 0);
            end else begin
               r_exp = exp_resp.pop_front();
               check("resp_err", resp_err, r_exp.err);
               check("resp_data", resp_data, r_exp.data);
               if (!r_exp.err) check("ready_to_resp_latency", nidx - rise_n, 1);
            end
         end
      end
   end

   // Drive point: 2 time units after the rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [7:0] wd);
      int k;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 300) begin
         tick(1);
         k++;
      end
      if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
      tick(1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input int budget);
      int start;
      int k;
      start = resp_count;
      k = 0;
      while (resp_count == start && k < budget) begin
         tick(1);
         k++;
      end
      check("resp_arrived", resp_count > start, 1);
      check("all_steps_issued", exp_steps.size(), 0);
      tick(1);
   endtask

   function automatic int count_reads();
      int c;
      c = 0;
      foreach (log_steps[i]) if (log_steps[i].kind == K_R) c++;
      return c;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int rc;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_addr  = 16'h0000;
      cmd_wdata = 8'h00;
      stuck     = 1'b0;
      read_val  = 8'h00;
      tick(3);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_strobes", {bdm_do_read, bdm_do_write, bdm_do_delay}, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_data_in", bdm_data_in, 0);
      tick(1);
      rst = 1'b0;
      tick(2);

      // BACKGROUND
      log_steps.delete();
      plan(3'd0, 16'h0, 8'h0, 8'h0, 99, 1'b1, 1'b0);
      send(3'd0, 16'h0, 8'h0);
      wait_resp(100);
      check("bg_nstrobes", log_steps.size(), 2);
      check("bg_byte0", log_steps[0].data, 8'h90);
      check("bg_kind1", log_steps[1].kind, K_D);
      check("bg_byte1", log_steps[1].data, 8'd4);
      check("bg_resp", {last_resp.err, last_resp.data}, 9'h000);

      // READ_BYTE 0x1234 -> A5
      log_steps.delete();
      read_val = 8'hA5;
      plan(3'd4, 16'h1234, 8'h0, 8'hA5, 99, 1'b1, 1'b0);
      send(3'd4, 16'h1234, 8'h0);
      wait_resp(200);
      check("rb_byte1", log_steps[1].data, 8'h12);
      check("rb_byte2", log_steps[2].data, 8'h34);
      check("rb_kind4", log_steps[4].kind, K_R);
      check("rb_resp", {last_resp.err, last_resp.data}, 9'h0A5);

      // WRITE_BYTE 0xFF80 <- 3C
      log_steps.delete();
      plan(3'd5, 16'hFF80, 8'h3C, 8'h0, 99, 1'b1, 1'b0);
      send(3'd5, 16'hFF80, 8'h3C);
      wait_resp(200);
      check("wb_nstrobes", log_steps.size(), 5);
      check("wb_byte3", log_steps[3].data, 8'h3C);
      check("wb_no_read", count_reads(), 0);
      check("wb_resp_err", last_resp.err, 0);

      // READ_STATUS and WRITE_CONTROL against the plan only
      read_val = 8'h7E;
      plan(3'd2, 16'h0, 8'h0, 8'h7E, 99, 1'b1, 1'b0);
      send(3'd2, 16'h0, 8'h0);
      wait_resp(200);
      plan(3'd3, 16'h0, 8'h55, 8'h0, 99, 1'b1, 1'b0);
      send(3'd3, 16'h0, 8'h55);
      wait_resp(200);

      // Illegal ops
      for (int op = 6; op < 8; op++) begin
         log_steps.delete();
         plan(3'(op), 16'h0, 8'h0, 8'h0, 99, 1'b1, 1'b0);
         send(3'(op), 16'hABCD, 8'hFF);
         wait_resp(20);
         check("illegal_resp_latency_le2", (resp_n - acc_n) <= 2, 1);
         check("illegal_resp_err", last_resp.err, 1);
         check("illegal_nstrobes", log_steps.size(), 0);
      end

      // Timeout: bdm never comes back after the first strobe
      log_steps.delete();
      stuck = 1'b1;
      plan(3'd1, 16'h0, 8'h0, 8'h0, 1, 1'b1, 1'b1);
      send(3'd1, 16'h0, 8'h0);
      wait_resp(400);
      check("to_resp_delay_ok", (resp_n - strobe_n) >= 95 && (resp_n - strobe_n) <= 110, 1);
      check("to_resp", {last_resp.err, last_resp.data}, 9'h100);
      stuck = 1'b0;
      k = 0;
      while (!bdm_ready && k < 50) begin
         tick(1);
         k++;
      end
      tick(10);
      check("to_no_more_strobes", log_steps.size(), 1);

      // Reset in the middle of READ_BYTE after its second write
      log_steps.delete();
      plan(3'd4, 16'h1234, 8'h0, 8'h0, 2, 1'b0, 1'b0);
      rc = resp_count;
      send(3'd4, 16'h1234, 8'h0);
      k = 0;
      while (log_steps.size() < 2 && k < 100) begin
         tick(1);
         k++;
      end
      check("mid_rst_two_writes", log_steps.size(), 2);
      rst = 1'b1;
      tick(1);
      @(negedge clk);
      check("mid_rst_strobes", {bdm_do_read, bdm_do_write, bdm_do_delay}, 0);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_resp_valid", resp_valid, 0);
      tick(1);
      rst = 1'b0;
      tick(5);
      check("mid_rst_no_resp", resp_count, rc);
      check("mid_rst_steps_done", exp_steps.size(), 0);
      log_steps.delete();
      plan(3'd1, 16'h0, 8'h0, 8'h0, 99, 1'b1, 1'b0);
      send(3'd1, 16'h0, 8'h0);
      wait_resp(100);
      check("go_nstrobes", log_steps.size(), 2);
      check("go_byte0", log_steps[0].data, 8'h08);
      check("go_kind1", log_steps[1].kind, K_D);
      check("go_resp_err", last_resp.err, 0);
      check("resp_queue_empty", exp_resp.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
